// File: rtl/dram_arb_pkg.sv
// Package: dram_arb_pkg
// Shared definitions for the DRAM request arbiter: FSM state encoding and the
// default widths that match the dram_controller user port.
package dram_arb_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StIssue  = 3'd1,
    StRun    = 3'd2,
    StRdWait = 3'd3,
    StDone   = 3'd4
  } arb_state_e;

  localparam int unsigned DefNumReq     = 4;
  localparam int unsigned DefAddrWidth  = 9;
  localparam int unsigned DefDataWidth  = 2;
  localparam int unsigned DefTimeoutCyc = 64;

endpackage

// File: rtl/dram_req_arbiter_rr_pick.sv
// Module: rr_pick
// Combinational round-robin selector. Searches the request vector starting at
// the position just after last_idx and wrapping, returning the first set bit.
// Ports:
//   req      in   NUM_REQ  request vector
//   last_idx in   IDX_W    most recently served requester
//   idx      out  IDX_W    selected requester (0 when none)
//   any      out  1        at least one request is set
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Offset 1 first so the last winner gets the lowest priority this round.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand     = (32'(last_idx) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dram_req_arbiter.sv
// Module: dram_req_arbiter
// Shares one dram_controller user port among NUM_REQ requesters in round-robin
// order. One command is in flight at a time; the controller enable is held for
// the command's lifetime and the completion/read data are routed back to the
// granted requester.
// Optional feature macro: DRAM_ARB_TIMEOUT_EN (watchdog that forces completion
// with r_err after TIMEOUT_CYC cycles without progress).
// Ports:
//   u_clk, u_rst_n   clock, asynchronous active-low reset
//   r_req/r_cmd      per-requester request (held until r_done) and 1=write/0=read
//   r_addr/r_wdata   flattened per-requester address and write data
//   r_done           one-hot single-cycle completion pulse
//   r_rdata          read data, valid with r_done of a read
//   r_err            single-cycle timeout flag alongside r_done
//   m_en/m_addr/m_wdata/m_cmd        to controller u_en/u_addr/u_data_i/u_cmd
//   m_cmd_ack/m_busy/m_rdata/m_rvalid from controller u_cmd_ack/u_busy/u_data_o/u_data_valid
module dram_req_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                         u_clk,
  input  logic                         u_rst_n,
  input  logic [NUM_REQ-1:0]           r_req,
  input  logic [NUM_REQ-1:0]           r_cmd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] r_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] r_wdata,
  output logic [NUM_REQ-1:0]           r_done,
  output logic [DATA_WIDTH-1:0]        r_rdata,
  output logic [NUM_REQ-1:0]           r_err,
  output logic                         m_en,
  output logic [ADDR_WIDTH-1:0]        m_addr,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic                         m_cmd,
  input  logic                         m_cmd_ack,
  input  logic                         m_busy,
  input  logic [DATA_WIDTH-1:0]        m_rdata,
  input  logic                         m_rvalid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]      grant_q, last_q, last_d, pick_idx;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                  cmd_q;
  logic                  seen_q, seen_d;
  logic                  grant_now;
  logic                  cap_rd;

  // Unpacked views of the flattened request buses for indexing by grant.
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = r_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = r_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (r_req),
    .last_idx (last_q),
    .idx      (pick_idx),
    .any      (pick_any)
  );

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            wd_active;
  logic            wd_expire;

  assign wd_active = (state_q == StIssue) || (state_q == StRun) || (state_q == StRdWait);
  assign wd_expire = wd_active && (wd_q == WD_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    seen_d    = seen_q;
    m_en      = 1'b0;
    grant_now = 1'b0;
    cap_rd    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_now = 1'b1;
          seen_d    = 1'b0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        m_en = 1'b1;
        if (m_cmd_ack) state_d = StRun;
      end
      StRun: begin
        // Drop enable in the cycle busy falls so the idle controller does not
        // resample it as a new command.
        if (seen_q && !m_busy) begin
          state_d = cmd_q ? StDone : StRdWait;
        end else begin
          m_en = 1'b1;
          if (m_busy) seen_d = 1'b1;
        end
      end
      StRdWait: begin
        if (m_rvalid) begin
          cap_rd  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef DRAM_ARB_TIMEOUT_EN
    wd_d  = wd_q;
    err_d = err_q;
    if (grant_now) begin
      wd_d  = '0;
      err_d = 1'b0;
    end else if (wd_active) begin
      wd_d = wd_q + WD_W'(1);
    end
    // A normal completion in the expiry cycle wins over the timeout.
    if (wd_expire && (state_d != StDone)) begin
      state_d = StDone;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      seen_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cmd_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      seen_q  <= seen_d;
      if (grant_now) begin
        grant_q <= pick_idx;
        addr_q  <= addr_arr[pick_idx];
        wdata_q <= wdata_arr[pick_idx];
        cmd_q   <= r_cmd[pick_idx];
        // Cleared here so a timed-out read returns zero.
        rdata_q <= '0;
      end else if (cap_rd) begin
        rdata_q <= m_rdata;
      end
    end
  end

`ifdef DRAM_ARB_TIMEOUT_EN
  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign r_err = ((state_q == StDone) && err_q) ? (NUM_REQ'(1) << grant_q) : '0;
`else
  // Keeps TIMEOUT_CYC referenced when the watchdog is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign r_err          = '0;
`endif

  assign r_done  = (state_q == StDone) ? (NUM_REQ'(1) << grant_q) : '0;
  assign r_rdata = (state_q == StDone) ? rdata_q : '0;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_cmd   = cmd_q;

endmodule
